// File: rtl/branch_predictor_table_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_table_if
//
// Bundles the fetch-side lookup and the execute-side update of the branch
// predictor table into one interface.
//
//   master : the pipeline side. It drives lookups and resolved-branch updates
//            and receives the registered prediction and the debug/statistics
//            outputs.
//   slave  : the predictor table.
//
// Signals
//   req_valid  lookup request this cycle
//   req_pc     PC of the branch being looked up
//   pred_valid prediction valid, one cycle after req_valid
//   pred_taken predicted direction
//   pred_idx   table index used; fetch carries it down to execute
//   upd_valid  resolved-branch update this cycle
//   upd_idx    index returned with the branch (taken from pred_idx)
//   upd_taken  actual direction
//   upd_pred   direction that was predicted for this branch
//   ghist      current global history (debug); width max(HIST_W,1)
//   miss_count saturating count of mispredicted updates
// ---------------------------------------------------------------------------
interface branch_predictor_table_if #(
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    localparam int GH_W = (HIST_W > 0) ? HIST_W : 1;

    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_pred;
    logic [GH_W-1:0]   ghist;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        output req_valid, req_pc,
        output upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_valid, pred_taken, pred_idx,
        input  ghist, miss_count
    );

    modport slave (
        input  req_valid, req_pc,
        input  upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_valid, pred_taken, pred_idx,
        output ghist, miss_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// branch_predictor_table
//
// Branch direction predictor: 2^IDX_W saturating counters of CTR_W bits,
// indexed by PC[IDX_W+1:2] XOR the global history (gshare). With HIST_W = 0
// the history term vanishes and the table is a plain bimodal predictor.
//
// A lookup presented on the bus returns a registered prediction one cycle
// later. A resolved-branch update trains the counter at upd_idx, shifts the
// outcome into the global history and counts mispredictions. History is only
// updated at resolution; there is no speculative history or recovery.
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset; overrides any lookup or update
//   bp     branch_predictor_table_if.slave (lookup, update, debug outputs)
//
// Parameters
//   CTR_W  counter width, 1..4
//   IDX_W  table index width, 1..10
//   HIST_W global history length, 0..IDX_W (0 = bimodal)
//   PC_W   PC width, at least IDX_W+2
//   CNT_W  mispredict counter width
// The interface instance must be built with the same IDX_W/HIST_W/PC_W/CNT_W.
// ---------------------------------------------------------------------------
module branch_predictor_table #(
    parameter int CTR_W  = 2,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_predictor_table_if.slave  bp
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int GH_W  = (HIST_W > 0) ? HIST_W : 1;

    // Weakly-not-taken: MSB clear, all lower bits set (0 for CTR_W = 1).
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CNT_W-1:0] MISS_MAX = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CTR_W-1:0] r_table [DEPTH];
    logic [GH_W-1:0]  r_ghist;
    logic [CNT_W-1:0] r_miss_count;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] w_hist_idx;     // history zero-extended to index width
    logic [IDX_W-1:0] w_req_idx;      // lookup index
    logic [GH_W-1:0]  w_ghist_next;   // history after this update
    logic [CTR_W-1:0] w_upd_ctr;      // counter selected by upd_idx
    logic [CTR_W-1:0] w_upd_ctr_next; // its trained value
    logic             w_mispredict;
    logic             w_unused_pc;

    generate
        if (HIST_W == 0) begin : g_bimodal
            assign w_hist_idx   = '0;
            assign w_ghist_next = '0;
        end else begin : g_gshare
            // Short histories occupy the low index bits; upper bits come
            // straight from the PC.
            assign w_hist_idx   = IDX_W'(r_ghist);
            // Shift left and insert the newest outcome at the LSB; the cast
            // drops the oldest bit (and degenerates to upd_taken for HIST_W=1).
            assign w_ghist_next = GH_W'({r_ghist, bp.upd_taken});
        end
    endgenerate

    // PC[1:0] never selects a counter; instructions are word aligned.
    assign w_req_idx    = bp.req_pc[IDX_W+1:2] ^ w_hist_idx;
    assign w_mispredict = bp.upd_pred ^ bp.upd_taken;

    // Only a slice of the PC feeds the index; fold the rest into a sink.
    assign w_unused_pc  = ^bp.req_pc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned and a latch is never inferred.
        w_upd_ctr      = r_table[bp.upd_idx];
        w_upd_ctr_next = w_upd_ctr;
        if (bp.upd_taken) begin
            if (w_upd_ctr != CTR_MAX) begin
                w_upd_ctr_next = w_upd_ctr + CTR_W'(1);
            end
        end else begin
            if (w_upd_ctr != '0) begin
                w_upd_ctr_next = w_upd_ctr - CTR_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the counter array is deliberately reset: a reset has to
            // discard all training, so the table is built from flops rather
            // than an un-initialised RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CTR_INIT;
            end
            r_ghist      <= '0;
            r_miss_count <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            // Lookup. pred_taken/pred_idx hold their last values when idle.
            r_pred_valid <= bp.req_valid;
            if (bp.req_valid) begin
                // NOTE: non-blocking assignments make the lookup read the
                // pre-update table and history even when the update below
                // hits the same entry in this cycle (read-before-write).
                r_pred_taken <= r_table[w_req_idx][CTR_W-1];
                r_pred_idx   <= w_req_idx;
            end

            // Resolved-branch update.
            if (bp.upd_valid) begin
                r_table[bp.upd_idx] <= w_upd_ctr_next;
                r_ghist             <= w_ghist_next;
                if (w_mispredict && (r_miss_count != MISS_MAX)) begin
                    r_miss_count <= r_miss_count + CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign bp.pred_valid = r_pred_valid;
    assign bp.pred_taken = r_pred_taken;
    assign bp.pred_idx   = r_pred_idx;
    assign bp.ghist      = r_ghist;
    assign bp.miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor_table.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_table
//
// Directed bench for branch_predictor_table. Two instances share clk/rst_n:
//   dut_g : default gshare configuration (CTR_W=2, IDX_W=4, HIST_W=4, CNT_W=16)
//   dut_b : bimodal with a narrow miss counter (HIST_W=0, CNT_W=4)
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_branch_predictor_table;

    logic clk;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    branch_predictor_table_if #(.IDX_W(4), .HIST_W(4), .PC_W(32), .CNT_W(16)) bus_g ();
    branch_predictor_table_if #(.IDX_W(4), .HIST_W(0), .PC_W(32), .CNT_W(4))  bus_b ();

    branch_predictor_table #(
        .CTR_W(2), .IDX_W(4), .HIST_W(4), .PC_W(32), .CNT_W(16)
    ) dut_g (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus_g)
    );

    branch_predictor_table #(
        .CTR_W(2), .IDX_W(4), .HIST_W(0), .PC_W(32), .CNT_W(4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look_g(input logic [31:0] pc);
        bus_g.req_valid = 1'b1;
        bus_g.req_pc    = pc;
        tick();
        bus_g.req_valid = 1'b0;
    endtask

    task automatic look_b(input logic [31:0] pc);
        bus_b.req_valid = 1'b1;
        bus_b.req_pc    = pc;
        tick();
        bus_b.req_valid = 1'b0;
    endtask

    task automatic upd_g(input logic [3:0] idx, input logic taken, input logic pred);
        bus_g.upd_valid = 1'b1;
        bus_g.upd_idx   = idx;
        bus_g.upd_taken = taken;
        bus_g.upd_pred  = pred;
        tick();
        bus_g.upd_valid = 1'b0;
    endtask

    task automatic upd_b(input logic [3:0] idx, input logic taken, input logic pred);
        bus_b.upd_valid = 1'b1;
        bus_b.upd_idx   = idx;
        bus_b.upd_taken = taken;
        bus_b.upd_pred  = pred;
        tick();
        bus_b.upd_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        bus_g.req_valid = 1'b0; bus_g.req_pc = '0;
        bus_g.upd_valid = 1'b0; bus_g.upd_idx = '0;
        bus_g.upd_taken = 1'b0; bus_g.upd_pred = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_pc = '0;
        bus_b.upd_valid = 1'b0; bus_b.upd_idx = '0;
        bus_b.upd_taken = 1'b0; bus_b.upd_pred = 1'b0;

        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_pred_valid", bus_g.pred_valid, 0);
        check("rst_pred_taken", bus_g.pred_taken, 0);
        check("rst_pred_idx",   bus_g.pred_idx,   0);
        check("rst_ghist",      bus_g.ghist,      0);
        check("rst_miss",       bus_g.miss_count, 0);
        check("rst_b_miss",     bus_b.miss_count, 0);

        // First lookup: PC 0x40 -> idx 0, counter 01 -> not taken
        look_g(32'h40);
        check("first_valid", bus_g.pred_valid, 1);
        check("first_taken", bus_g.pred_taken, 0);
        check("first_idx",   bus_g.pred_idx,   0);
        tick();
        check("idle_valid",  bus_g.pred_valid, 0);
        check("idle_idx",    bus_g.pred_idx,   0);

        // Bimodal saturation and direction change at idx 3 (PC 0x0C)
        upd_b(4'd3, 1'b1, 1'b1);             // 01 -> 10
        upd_b(4'd3, 1'b1, 1'b1);             // 10 -> 11
        look_b(32'h0C);
        check("bim_taken_11", bus_b.pred_taken, 1);
        check("bim_idx",      bus_b.pred_idx,   3);
        upd_b(4'd3, 1'b1, 1'b1);             // stays 11
        look_b(32'h0C);
        check("bim_sat_hi",   bus_b.pred_taken, 1);
        upd_b(4'd3, 1'b0, 1'b0);             // 11 -> 10
        look_b(32'h0C);
        check("bim_10",       bus_b.pred_taken, 1);
        upd_b(4'd3, 1'b0, 1'b0);             // 10 -> 01
        look_b(32'h0C);
        check("bim_01",       bus_b.pred_taken, 0);
        upd_b(4'd3, 1'b0, 1'b0);             // 01 -> 00
        upd_b(4'd3, 1'b0, 1'b0);             // stays 00
        upd_b(4'd3, 1'b1, 1'b1);             // 00 -> 01
        look_b(32'h0C);
        check("bim_sat_lo",   bus_b.pred_taken, 0);
        upd_b(4'd3, 1'b1, 1'b1);             // 01 -> 10
        look_b(32'h0C);
        check("bim_lo_up",    bus_b.pred_taken, 1);
        check("bim_ghist",    bus_b.ghist,      0);
        check("bim_no_miss",  bus_b.miss_count, 0);

        // Mispredict counter saturation (CNT_W = 4)
        for (int i = 0; i < 10; i++) upd_b(4'd9, i[0], ~i[0]);
        check("miss_10", bus_b.miss_count, 10);
        for (int i = 0; i < 5; i++)  upd_b(4'd9, i[0], ~i[0]);
        check("miss_15", bus_b.miss_count, 15);
        for (int i = 0; i < 5; i++)  upd_b(4'd9, i[0], ~i[0]);
        check("miss_sat", bus_b.miss_count, 15);
        for (int i = 0; i < 5; i++)  upd_b(4'd9, i[0], i[0]);
        check("miss_match", bus_b.miss_count, 15);

        // History XOR: T,T,N,T -> 1101; PC 0x0C -> idx 3 ^ D = E
        upd_g(4'd7, 1'b1, 1'b1);
        upd_g(4'd7, 1'b1, 1'b1);
        upd_g(4'd7, 1'b0, 1'b0);
        upd_g(4'd7, 1'b1, 1'b1);
        check("hist_1101", bus_g.ghist, 4'hD);
        look_g(32'h0C);
        check("hist_idx",   bus_g.pred_idx,   4'hE);
        check("hist_taken", bus_g.pred_taken, 0);
        check("hist_miss",  bus_g.miss_count, 0);

        // Same-cycle collision at idx 5: PC 0x20 -> 8 ^ D = 5
        bus_g.req_valid = 1'b1;
        bus_g.req_pc    = 32'h20;
        bus_g.upd_valid = 1'b1;
        bus_g.upd_idx   = 4'd5;
        bus_g.upd_taken = 1'b1;
        bus_g.upd_pred  = 1'b1;
        tick();
        bus_g.req_valid = 1'b0;
        bus_g.upd_valid = 1'b0;
        check("coll_idx",   bus_g.pred_idx,   5);
        check("coll_taken", bus_g.pred_taken, 0);
        check("coll_ghist", bus_g.ghist,      4'hB);
        // History now 1011: PC 0x38 -> E ^ B = 5, counter 10
        look_g(32'h38);
        check("coll_rep_idx",   bus_g.pred_idx,   5);
        check("coll_rep_taken", bus_g.pred_taken, 1);

        // Train idx 3 to 11 with two mispredicted updates
        upd_g(4'd3, 1'b1, 1'b0);
        upd_g(4'd3, 1'b1, 1'b0);
        check("pre_rst_ghist", bus_g.ghist,      4'hF);
        check("pre_rst_miss",  bus_g.miss_count, 2);
        // History 1111: PC 0x30 -> C ^ F = 3
        look_g(32'h30);
        check("pre_rst_idx",   bus_g.pred_idx,   3);
        check("pre_rst_taken", bus_g.pred_taken, 1);

        // Reset together with a lookup and an update
        rst_n = 1'b0;
        bus_g.req_valid = 1'b1;
        bus_g.req_pc    = 32'h0C;
        bus_g.upd_valid = 1'b1;
        bus_g.upd_idx   = 4'd3;
        bus_g.upd_taken = 1'b1;
        bus_g.upd_pred  = 1'b0;
        tick();
        bus_g.req_valid = 1'b0;
        bus_g.upd_valid = 1'b0;
        rst_n = 1'b1;
        check("mid_rst_valid", bus_g.pred_valid, 0);
        check("mid_rst_ghist", bus_g.ghist,      0);
        check("mid_rst_miss",  bus_g.miss_count, 0);
        check("mid_rst_taken", bus_g.pred_taken, 0);
        check("mid_rst_idx",   bus_g.pred_idx,   0);
        check("mid_rst_b_miss", bus_b.miss_count, 0);
        look_g(32'h0C);
        check("post_rst_idx",   bus_g.pred_idx,   3);
        check("post_rst_taken", bus_g.pred_taken, 0);
        check("post_rst_valid", bus_g.pred_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised branch direction predictor: a table of 2^IDX_W saturating counters of CTR_W bits, indexed by PC bits XOR a global history register (gshare; bimodal when HIST_W = 0). Sits beside the fetch stage: fetch issues a lookup and gets a registered prediction one cycle later. The execute stage reports resolved outcomes, which train the selected counter, shift the history and count mispredictions.

## Interface
- CTR_W, 2: counter width, legal 1..4.
- IDX_W, 4: table index width; depth = 2^IDX_W entries, legal 1..10.
- HIST_W, 4: global history length, legal 0..IDX_W; 0 selects bimodal.
- PC_W, 32: PC width; requires PC_W ≥ IDX_W+2.
- CNT_W, 16: mispredict counter width.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  lookup request this cycle.
- req_pc  in  PC_W  PC of the branch being looked up.
- pred_valid  out  1  prediction valid, one cycle after req_valid.
- pred_taken  out  1  predicted direction, MSB of the selected counter.
- pred_idx  out  IDX_W  table index used; fetch carries it to execute.
- upd_valid  in  1  resolved-branch update this cycle.
- upd_idx  in  IDX_W  index returned with the branch, from pred_idx.
- upd_taken  in  1  actual direction.
- upd_pred  in  1  direction that was predicted for this branch.
- ghist  out  max(HIST_W,1)  current global history (debug); 0 when HIST_W=0.
- miss_count  out  CNT_W  saturating count of updates with upd_pred ≠ upd_taken.

## Operation
- Index: idx = req_pc[IDX_W+1:2] XOR {(IDX_W−HIST_W) zeros, ghist}. PC bits [1:0] are ignored.
- Counter init value: WNT = 2^(CTR_W−1) − 1, e.g. 2'b01 for CTR_W=2. For CTR_W=1 the init value is 0.
- Lookup: on req_valid, register pred_taken = table[idx][CTR_W−1], pred_idx = idx, pred_valid = 1.
- With no request, pred_valid = 0. pred_taken and pred_idx hold their last values.
- Update on upd_valid:
  - upd_taken = 1: table[upd_idx] increments, saturating at all-ones.
  - upd_taken = 0: table[upd_idx] decrements, saturating at zero.
  - History: ghist ← {ghist[HIST_W−2:0], upd_taken}, i.e. shift left and insert at the LSB. For HIST_W=1, ghist ← upd_taken.
  - Mispredict: if upd_pred ≠ upd_taken, miss_count increments, saturating at all-ones.
- History is updated only at resolution. There is no speculative history and no recovery logic.
- Reset (rst_n low at a rising edge):
  - all counters ← WNT; ghist ← 0; miss_count ← 0;
  - pred_valid ← 0, pred_taken ← 0, pred_idx ← 0.
  - Reset overrides any req_valid or upd_valid in the same cycle.
- Reset mid-operation discards all training. An in-flight pred_valid is dropped on the next edge.

## Timing
- Lookup latency: exactly 1 cycle. req_valid at edge N gives pred_valid/pred_taken at edge N+1.
- Back-to-back requests every cycle are supported: one lookup per cycle, no stall.
- Update takes effect at the edge on which upd_valid is sampled.
- Simultaneous req_valid and upd_valid:
  - Both are performed in the same cycle.
  - The lookup uses the pre-update history and pre-update table contents (read-before-write), even when idx = upd_idx.
  - The update result is visible to lookups from the next cycle.
- Saturation boundaries are stable indefinitely:
  - all-ones + taken stays all-ones;
  - zero + not-taken stays zero;
  - miss_count all-ones stays all-ones.
- No output depends combinationally on any input; all outputs are registered.

## Test plan
- **Reset and first lookup.** Defaults; after reset, req_pc=0x40 → next cycle pred_valid=1, pred_taken=0, pred_idx=0x0. ghist=0, miss_count=0.
- **Saturation and direction change.** Bimodal (HIST_W=0), idx 3: after 2 taken updates the counter is 11; a 3rd taken keeps it at 11. Lookup of req_pc=0x0C gives pred_taken=1. Then 2 not-taken updates → counter 01, pred_taken=0. Then 2 more → counter 00, where it stays.
- **History XOR.** Defaults: updates taken, taken, not-taken, taken → ghist=4'b1101. req_pc=0x0C then gives pred_idx = 0x3 ^ 0xD = 0xE.
- **Same-cycle read/write collision.** Counter at idx 5 = 01. Drive req (index 5) and upd (idx 5, taken) in the same cycle → prediction 0. A repeat lookup the next cycle → prediction 1 (counter now 10).
- **Mispredict counter.** With CNT_W=4: 20 updates with upd_pred≠upd_taken → miss_count=15 (saturated). 5 matching updates → unchanged at 15.
- **Reset mid-stream.** After training idx 3 to 11 and ghist≠0, assert rst_n=0 together with req_valid and upd_valid. Next cycle: pred_valid=0, ghist=0, miss_count=0. A later lookup of idx 3 → pred_taken=0.
